bram_fill_ctrl: RTL and testbench
=================================

Name: bram_fill_ctrl

Overview:
Parametrised single-port block RAM with a built-in fill sequencer. It is the successor to the fixed 16x8 block-RAM top. Width and depth are generic. On request, a hardware engine writes a selectable pattern to every address, one word per clock, with a busy/done handshake. User read/write access shares the same port and is arbitrated against the engine. It sits between test/control logic and any datapath needing a preloaded or scrubbed buffer.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
wea  in  1  user write enable for addra/dina
addra  in  ADDR_W  user address (read and write)
dina  in  DATA_W  user write data
douta  out  DATA_W  registered read data of addra
fill_start  in  1  single-cycle request to start a fill
fill_mode  in  2  pattern select, sampled with fill_start
fill_seed  in  DATA_W  pattern seed, sampled with fill_start
busy  out  1  high while the fill engine owns the write port
fill_done  out  1  one-cycle pulse after the last fill write
wr_drop  out  1  one-cycle pulse: user write discarded during fill

Behaviour:
- Reset values: douta=0, busy=0, fill_done=0, wr_drop=0, FSM=IDLE, fill counter=0. Memory contents are NOT cleared by rst.
- Read: douta <= mem[addra] every cycle; latency 1. Reads stay active during a fill.
- Same-address read/write in one cycle (user or engine) is read-first: douta shows the old word.
- User write: when wea=1 and busy=0, mem[addra] <= dina at the edge.
- FSM states IDLE, FILL, DONE.
- IDLE -> FILL on fill_start=1. That edge latches mode and seed, clears the index to 0 and sets busy=1. A user write in the same cycle as fill_start is still accepted, because busy is 0 in that cycle.
- FILL: each cycle, mem[idx] <= pattern(idx) and idx increments. After the write at idx=DEPTH-1, go to DONE. Total fill writes = DEPTH, on consecutive cycles starting the cycle after fill_start.
- DONE: lasts one cycle. fill_done=1, busy=0, then IDLE. The counter wraps to 0 and is unused.
- Patterns, arithmetic mod 2**DATA_W:
  - mode 0 CONST: seed
  - mode 1 INCR: seed + idx
  - mode 2 DECR: seed - idx
  - mode 3 ADDR: idx zero-extended, or truncated to DATA_W (seed ignored)
- wea=1 while busy=1: the write is discarded and wr_drop pulses in that cycle (registered, visible the next cycle).
- fill_start while busy=1, or in the DONE cycle: ignored. No queueing, no restart.
- rst mid-fill: abort immediately. Words already written keep their pattern; the rest keep their prior contents. busy=0 the cycle after rst.
- Changes to fill_mode/fill_seed during FILL have no effect.

Decomposition:
- Package bram_fill_pkg: mode constants FILL_CONST=0, FILL_INCR=1, FILL_DECR=2, FILL_ADDR=3, and the FSM state encoding (IDLE=0, FILL=1, DONE=2).
- Sub-module bram_sp: generic synchronous single-port RAM (DATA_W, ADDR_W), read-first, one write port. The top muxes the write port between user and engine, and keeps the FSM, counter and pattern generator.

Test Plan:
- Defaults. Reset, write 8'hA0+i to addresses 0..15 with wea, then read 0..15 -> douta equals 8'hA0+i one cycle after each address is applied.
- fill_start with mode=1, seed=8'hF8 -> busy high for 16 cycles, then a fill_done pulse. Readback: addr0=F8, addr7=FF, addr8=00 (wrap), addr15=07.
- Mode=2, seed=8'h03 -> addr0=03, addr3=00, addr4=FF, addr15=F4. Mode=3 -> addr i reads i. Mode=0, seed=5A -> all words 5A.
- During a mode-0 fill (seed=00), assert wea at addr 5 with dina=77 -> wr_drop pulses and addr5 reads 00. A second fill_start mid-fill -> ignored; fill_done pulses once.
- Pre-load all words 11, start a mode-0 fill with seed=EE, assert rst on the 4th fill cycle -> busy=0 the next cycle and no fill_done. Addresses 0..3=EE, 4..15=11.
- Parameter sweep DATA_W=16, ADDR_W=6 -> a mode-1 fill takes 64 cycles; addr63 reads seed+63 mod 2**16. Same-cycle write/read of one address returns the old data.

Source files
------------

// File: rtl/bram_fill_ctrl_pkg.sv
// Shared definitions for the block RAM fill controller: pattern mode codes
// and the fill sequencer state encoding.
package bram_fill_pkg;

    localparam logic [1:0] FILL_CONST = 2'd0;
    localparam logic [1:0] FILL_INCR  = 2'd1;
    localparam logic [1:0] FILL_DECR  = 2'd2;
    localparam logic [1:0] FILL_ADDR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/bram_sp.sv
// Generic synchronous RAM with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module bram_sp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array: written on we_i, never cleared by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read data; samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_fill_ctrl.sv
// Block RAM with a built-in fill sequencer. The engine owns the write port
// while busy and writes one pattern word per cycle to every address; user
// writes during that window are dropped and flagged. Reads are never blocked.
module bram_fill_ctrl
    import bram_fill_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    input  logic              fill_start,
    input  logic [1:0]        fill_mode,
    input  logic [DATA_W-1:0] fill_seed,
    output logic              busy,
    output logic              fill_done,
    output logic              wr_drop
);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] idx_ext;
    logic [DATA_W-1:0] pattern;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // Sequencer state, index, latched request parameters and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mode_q    <= FILL_CONST;
            seed_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic: IDLE waits for a request, FILL sweeps all addresses,
    // DONE is a single pulse cycle in which new requests are ignored.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        wr_drop_d = wea && (state_q == FILL);
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    idx_d   = '0;
                    mode_d  = fill_mode;
                    seed_d  = fill_seed;
                end
            end
            FILL: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pattern word for the current index, all arithmetic modulo 2**DATA_W.
    always_comb begin
        idx_ext = DATA_W'(idx_q);
        pattern = seed_q;
        unique case (mode_q)
            FILL_CONST: pattern = seed_q;
            FILL_INCR:  pattern = seed_q + idx_ext;
            FILL_DECR:  pattern = seed_q - idx_ext;
            FILL_ADDR:  pattern = idx_ext;
            default:    pattern = seed_q;
        endcase
    end

    // Write-port arbitration: the engine has exclusive ownership while busy.
    always_comb begin
        ram_we    = wea;
        ram_waddr = addra;
        ram_wdata = dina;
        if (state_q == FILL) begin
            ram_we    = 1'b1;
            ram_waddr = idx_q;
            ram_wdata = pattern;
        end
    end

    bram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addra),
        .rdata_o (douta)
    );

    assign busy      = (state_q == FILL);
    assign fill_done = (state_q == DONE);
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// Directed bench for bram_fill_ctrl: default 16x8 instance plus a 64x16
// instance for the wider/deeper configuration.
module tb_bram_fill_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wea;
    logic [3:0] addra;
    logic [7:0] dina;
    logic [7:0] douta;
    logic       fill_start;
    logic [1:0] fill_mode;
    logic [7:0] fill_seed;
    logic       busy;
    logic       fill_done;
    logic       wr_drop;

    logic        w_wea;
    logic [5:0]  w_addra;
    logic [15:0] w_dina;
    logic [15:0] w_douta;
    logic        w_fill_start;
    logic [1:0]  w_fill_mode;
    logic [15:0] w_fill_seed;
    logic        w_busy;
    logic        w_fill_done;
    logic        w_wr_drop;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    bram_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .douta      (douta),
        .fill_start (fill_start),
        .fill_mode  (fill_mode),
        .fill_seed  (fill_seed),
        .busy       (busy),
        .fill_done  (fill_done),
        .wr_drop    (wr_drop)
    );

    bram_fill_ctrl #(
        .DATA_W (16),
        .ADDR_W (6)
    ) dut_w (
        .clk        (clk),
        .rst        (rst),
        .wea        (w_wea),
        .addra      (w_addra),
        .dina       (w_dina),
        .douta      (w_douta),
        .fill_start (w_fill_start),
        .fill_mode  (w_fill_mode),
        .fill_seed  (w_fill_seed),
        .busy       (w_busy),
        .fill_done  (w_fill_done),
        .wr_drop    (w_wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wea = 1'b1; addra = a; dina = d;
        tick();
        wea = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        addra = a;
        tick();
        chk(tag, {24'h0, douta}, {24'h0, exp});
    endtask

    task automatic start_fill(input logic [1:0] m, input logic [7:0] s);
        fill_mode = m; fill_seed = s; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    // Count busy samples until it drops (bounded), then expect the done pulse.
    task automatic wait_fill(input string tag, input int unsigned exp_cycles);
        int unsigned cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            tick();
        end
        chk({tag, "_busy_cycles"}, cnt, exp_cycles);
        chk({tag, "_done_pulse"}, {31'h0, fill_done}, 32'h1);
        tick();
        chk({tag, "_done_clear"}, {31'h0, fill_done}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        wea = 1'b0; addra = '0; dina = '0;
        fill_start = 1'b0; fill_mode = '0; fill_seed = '0;
        w_wea = 1'b0; w_addra = '0; w_dina = '0;
        w_fill_start = 1'b0; w_fill_mode = '0; w_fill_seed = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_douta", {24'h0, douta}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, fill_done}, 32'h0);
        chk("rst_drop", {31'h0, wr_drop}, 32'h0);
        chk("rst_w_douta", {16'h0, w_douta}, 32'h0);
        chk("rst_w_busy", {31'h0, w_busy}, 32'h0);

        // User write / read
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hA0 + 8'(i));
        chk("idle_no_drop", {31'h0, wr_drop}, 32'h0);
        for (int i = 0; i < 16; i++) rd($sformatf("user_rd%0d", i), 4'(i), 8'hA0 + 8'(i));

        // INCR fill with wrap
        start_fill(2'd1, 8'hF8);
        wait_fill("incr", 16);
        rd("incr_a0", 4'd0, 8'hF8);
        rd("incr_a7", 4'd7, 8'hFF);
        rd("incr_a8", 4'd8, 8'h00);
        rd("incr_a15", 4'd15, 8'h07);

        // DECR fill
        start_fill(2'd2, 8'h03);
        wait_fill("decr", 16);
        rd("decr_a0", 4'd0, 8'h03);
        rd("decr_a3", 4'd3, 8'h00);
        rd("decr_a4", 4'd4, 8'hFF);
        rd("decr_a15", 4'd15, 8'hF4);

        // ADDR fill; seed must be ignored
        start_fill(2'd3, 8'h99);
        wait_fill("addr", 16);
        for (int i = 0; i < 16; i++) rd($sformatf("addr_rd%0d", i), 4'(i), 8'(i));

        // CONST fill; changing mode/seed mid-fill must not matter
        start_fill(2'd0, 8'h5A);
        fill_mode = 2'd1; fill_seed = 8'h00;
        wait_fill("const", 16);
        for (int i = 0; i < 16; i++) rd($sformatf("const_rd%0d", i), 4'(i), 8'h5A);

        // Dropped write and ignored restart during a fill
        begin
            int unsigned pulses = 0;
            start_fill(2'd0, 8'h00);
            tick();
            wea = 1'b1; addra = 4'd5; dina = 8'h77;
            tick();
            wea = 1'b0;
            chk("drop_pulse", {31'h0, wr_drop}, 32'h1);
            tick();
            chk("drop_clear", {31'h0, wr_drop}, 32'h0);
            fill_mode = 2'd3; fill_start = 1'b1;
            tick();
            fill_start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (fill_done) pulses++;
                tick();
            end
            chk("restart_one_done", pulses, 1);
            chk("restart_idle", {31'h0, busy}, 32'h0);
            rd("drop_a5", 4'd5, 8'h00);
            rd("drop_a15", 4'd15, 8'h00);
        end

        // Reset aborting a fill on its 4th write cycle
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h11);
        start_fill(2'd0, 8'hEE);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, fill_done}, 32'h0);
        begin
            int unsigned pulses = 0;
            for (int i = 0; i < 20; i++) begin
                if (fill_done) pulses++;
                tick();
            end
            chk("abort_no_done", pulses, 0);
        end
        for (int i = 0; i < 16; i++)
            rd($sformatf("abort_rd%0d", i), 4'(i), (i < 4) ? 8'hEE : 8'h11);

        // Wide/deep instance: 64-cycle INCR fill with 16-bit wrap
        begin
            int unsigned cnt = 0;
            w_fill_mode = 2'd1; w_fill_seed = 16'hFFF0; w_fill_start = 1'b1;
            tick();
            w_fill_start = 1'b0;
            while (w_busy && cnt < 200) begin
                cnt++;
                tick();
            end
            chk("w_busy_cycles", cnt, 64);
            chk("w_done_pulse", {31'h0, w_fill_done}, 32'h1);
            tick();
            w_addra = 6'd63;
            tick();
            chk("w_a63", {16'h0, w_douta}, 32'h002F);
            w_addra = 6'd0;
            tick();
            chk("w_a0", {16'h0, w_douta}, 32'hFFF0);
            // Same-cycle write and read of address 10: old word returned
            w_wea = 1'b1; w_addra = 6'd10; w_dina = 16'h5678;
            tick();
            w_wea = 1'b0;
            chk("w_rdfirst_old", {16'h0, w_douta}, 32'hFFFA);
            tick();
            chk("w_rdfirst_new", {16'h0, w_douta}, 32'h5678);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
